segmented_load_register: RTL and testbench

- Parametrised multi-segment register that assembles a wide value from a narrow data bus. Intended for memory address, instruction, jump and program-counter style registers wider than the 8-bit datapath.
- Generalises byte-half loading to NUM_SEG segments. Adds indexed load, auto-sequenced MSB-first load with a completion flag, whole-word load, and increment with carry.
- Sits between the 8-bit datapath/memory bus and address/control consumers.

---
 rtl/segmented_load_register.sv | 97 +++++++++
 tb/tb_segmented_load_register.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/segmented_load_register.sv
// Wide register assembled from a narrow segment bus: whole-word, indexed and
// MSB-first sequenced segment loads, plus a full-width increment with carry pulse.
module segmented_load_register #(
  parameter int unsigned SEG_W   = 8,
  parameter int unsigned NUM_SEG = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_SEG)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     full_load,
  input  logic [SEG_W*NUM_SEG-1:0] fullvaluein,
  input  logic                     seg_load,
  input  logic [PTR_W-1:0]         seg_sel,
  input  logic                     seq_load,
  input  logic                     seq_restart,
  input  logic                     increment,
  input  logic [SEG_W-1:0]         segvaluein,
  output logic [SEG_W*NUM_SEG-1:0] valueout,
  output logic [PTR_W-1:0]         seq_ptr,
  output logic                     seq_done,
  output logic                     carry_out
);

  localparam int unsigned W = SEG_W * NUM_SEG;
  localparam logic [PTR_W-1:0] TOP_SEG = PTR_W'(NUM_SEG - 1);

  logic [W-1:0]     r_value;
  logic [PTR_W-1:0] r_ptr;
  logic             r_done;
  logic             r_carry;

  logic [W-1:0]     w_value_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_done_nxt;
  logic             w_carry_nxt;
  logic [PTR_W-1:0] w_seq_idx;

  // A restart issued together with a winning seq_load redirects the write to the top segment.
  always_comb begin
    w_value_nxt = r_value;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = r_done;
    w_carry_nxt = 1'b0;
    w_seq_idx   = seq_restart ? TOP_SEG : r_ptr;

    if (full_load) begin
      w_value_nxt = fullvaluein;
    end else if (seg_load) begin
      // Out-of-range selects match no segment and silently write nothing.
      for (int unsigned s = 0; s < NUM_SEG; s++) begin
        if (PTR_W'(s) == seg_sel) begin
          w_value_nxt[s*SEG_W +: SEG_W] = segvaluein;
        end
      end
    end else if (seq_load) begin
      for (int unsigned s = 0; s < NUM_SEG; s++) begin
        if (PTR_W'(s) == w_seq_idx) begin
          w_value_nxt[s*SEG_W +: SEG_W] = segvaluein;
        end
      end
      if (w_seq_idx == '0) begin
        w_ptr_nxt  = TOP_SEG;
        w_done_nxt = 1'b1;
      end else begin
        w_ptr_nxt  = w_seq_idx - PTR_W'(1);
        w_done_nxt = 1'b0;
      end
    end else if (increment) begin
      {w_carry_nxt, w_value_nxt} = {1'b0, r_value} + (W+1)'(1);
    end

    if (seq_restart && !(seq_load && !full_load && !seg_load)) begin
      w_ptr_nxt  = TOP_SEG;
      w_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_ptr   <= TOP_SEG;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign valueout  = r_value;
  assign seq_ptr   = r_ptr;
  assign seq_done  = r_done;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_segmented_load_register.sv
// Directed bench: vector table on a 2x8 instance, hand sequences on a 3x8 instance
// and an asynchronous reset check.
module tb_segmented_load_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2-segment instance
  logic        rst2, fl2, sl2, ssel2, ql2, qr2, inc2;
  logic [15:0] fv2, vo2;
  logic [7:0]  sv2;
  logic        ptr2, done2, cy2;

  // 3-segment instance
  logic        rst3, fl3, sl3, ql3, qr3, inc3;
  logic [1:0]  ssel3, ptr3;
  logic [23:0] fv3, vo3;
  logic [7:0]  sv3;
  logic        done3, cy3;

  segmented_load_register #(.SEG_W(8), .NUM_SEG(2)) u_dut2 (
    .clock(clk), .reset(rst2), .full_load(fl2), .fullvaluein(fv2),
    .seg_load(sl2), .seg_sel(ssel2), .seq_load(ql2), .seq_restart(qr2),
    .increment(inc2), .segvaluein(sv2), .valueout(vo2), .seq_ptr(ptr2),
    .seq_done(done2), .carry_out(cy2)
  );

  segmented_load_register #(.SEG_W(8), .NUM_SEG(3)) u_dut3 (
    .clock(clk), .reset(rst3), .full_load(fl3), .fullvaluein(fv3),
    .seg_load(sl3), .seg_sel(ssel3), .seq_load(ql3), .seq_restart(qr3),
    .increment(inc3), .segvaluein(sv3), .valueout(vo3), .seq_ptr(ptr3),
    .seq_done(done3), .carry_out(cy3)
  );

  typedef struct {
    string       nm;
    logic        fl;
    logic [15:0] fv;
    logic        sl;
    logic        ssel;
    logic        ql;
    logic        qr;
    logic        inc;
    logic [7:0]  sv;
    logic [15:0] ev;
    logic        ep;
    logic        ed;
    logic        ec;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic fl, logic [15:0] fv, logic sl, logic ssel,
                              logic ql, logic qr, logic inc, logic [7:0] sv,
                              logic [15:0] ev, logic ep, logic ed, logic ec);
    vec_t v;
    v.nm = nm; v.fl = fl; v.fv = fv; v.sl = sl; v.ssel = ssel; v.ql = ql; v.qr = qr;
    v.inc = inc; v.sv = sv; v.ev = ev; v.ep = ep; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle2();
    fl2 = 0; fv2 = '0; sl2 = 0; ssel2 = 0; ql2 = 0; qr2 = 0; inc2 = 0; sv2 = '0;
  endtask

  task automatic idle3();
    fl3 = 0; fv3 = '0; sl3 = 0; ssel3 = '0; ql3 = 0; qr3 = 0; inc3 = 0; sv3 = '0;
  endtask

  task automatic chk2(input string nm, input logic [15:0] ev, input logic ep,
                      input logic ed, input logic ec);
    chk({nm, ".value"}, 24'(vo2), 24'(ev));
    chk({nm, ".ptr"},   24'(ptr2), 24'(ep));
    chk({nm, ".done"},  24'(done2), 24'(ed));
    chk({nm, ".carry"}, 24'(cy2), 24'(ec));
  endtask

  task automatic chk3(input string nm, input logic [23:0] ev, input logic [1:0] ep,
                      input logic ed);
    chk({nm, ".value"}, vo3, ev);
    chk({nm, ".ptr"},   24'(ptr3), 24'(ep));
    chk({nm, ".done"},  24'(done3), 24'(ed));
    chk({nm, ".carry"}, 24'(cy3), 24'(0));
  endtask

  initial begin
    //               name        fl fv       sl sel ql qr inc sv     exp_v  p  d  c
    vq.push_back(mk("seq_ab",    0, 16'h0,   0, 0, 1, 0, 0, 8'hAB, 16'hAB00, 0, 0, 0));
    vq.push_back(mk("seq_cd",    0, 16'h0,   0, 0, 1, 0, 0, 8'hCD, 16'hABCD, 1, 1, 0));
    vq.push_back(mk("full_12ff", 1, 16'h12FF,0, 0, 0, 0, 0, 8'h00, 16'h12FF, 1, 1, 0));
    vq.push_back(mk("seg0_34",   0, 16'h0,   1, 0, 0, 0, 0, 8'h34, 16'h1234, 1, 1, 0));
    vq.push_back(mk("seg1_56",   0, 16'h0,   1, 1, 0, 0, 0, 8'h56, 16'h5634, 1, 1, 0));
    vq.push_back(mk("full_ffff", 1, 16'hFFFF,0, 0, 0, 0, 0, 8'h00, 16'hFFFF, 1, 1, 0));
    vq.push_back(mk("inc_wrap",  0, 16'h0,   0, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 1, 1));
    vq.push_back(mk("inc_one",   0, 16'h0,   0, 0, 0, 0, 1, 8'h00, 16'h0001, 1, 1, 0));
    vq.push_back(mk("full_00ff", 1, 16'h00FF,0, 0, 0, 0, 0, 8'h00, 16'h00FF, 1, 1, 0));
    vq.push_back(mk("inc_ripple",0, 16'h0,   0, 0, 0, 0, 1, 8'h00, 16'h0100, 1, 1, 0));
    vq.push_back(mk("prio_full", 1, 16'h1111,1, 0, 1, 0, 1, 8'h77, 16'h1111, 1, 1, 0));
    vq.push_back(mk("prio_seg",  0, 16'h0,   1, 0, 1, 0, 0, 8'hEE, 16'h11EE, 1, 1, 0));
    vq.push_back(mk("restart",   0, 16'h0,   0, 0, 0, 1, 0, 8'h99, 16'h11EE, 1, 0, 0));
    vq.push_back(mk("seq_22",    0, 16'h0,   0, 0, 1, 0, 0, 8'h22, 16'h22EE, 0, 0, 0));
    vq.push_back(mk("rst_seq_33",0, 16'h0,   0, 0, 1, 1, 0, 8'h33, 16'h33EE, 0, 0, 0));
    vq.push_back(mk("seq_44",    0, 16'h0,   0, 0, 1, 0, 0, 8'h44, 16'h3344, 1, 1, 0));
    vq.push_back(mk("idle",      0, 16'h0,   0, 0, 0, 0, 0, 8'h00, 16'h3344, 1, 1, 0));
    vq.push_back(mk("full_ffff2",1, 16'hFFFF,0, 0, 0, 0, 0, 8'h00, 16'hFFFF, 1, 1, 0));
    vq.push_back(mk("inc_wrap2", 0, 16'h0,   0, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 1, 1));
    vq.push_back(mk("carry_drop",0, 16'h0,   0, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 0));

    idle2(); idle3();
    rst2 = 0; rst3 = 0;
    repeat (2) tick();
    chk2("reset2", 16'h0, 1'b1, 1'b0, 1'b0);
    chk3("reset3", 24'h0, 2'd2, 1'b0);
    rst2 = 1; rst3 = 1;
    tick();

    foreach (vq[i]) begin
      fl2 = vq[i].fl; fv2 = vq[i].fv; sl2 = vq[i].sl; ssel2 = vq[i].ssel;
      ql2 = vq[i].ql; qr2 = vq[i].qr; inc2 = vq[i].inc; sv2 = vq[i].sv;
      tick();
      chk2(vq[i].nm, vq[i].ev, vq[i].ep, vq[i].ed, vq[i].ec);
    end
    idle2();

    // Three-segment sequencing with a restart mid-sequence
    ql3 = 1; sv3 = 8'h01; tick(); chk3("s3_seq01", 24'h010000, 2'd1, 1'b0);
    idle3(); qr3 = 1;     tick(); chk3("s3_restart", 24'h010000, 2'd2, 1'b0);
    idle3(); ql3 = 1; sv3 = 8'h02; tick(); chk3("s3_seq02", 24'h020000, 2'd1, 1'b0);
    sv3 = 8'h03;          tick(); chk3("s3_seq03", 24'h020300, 2'd0, 1'b0);
    sv3 = 8'h04;          tick(); chk3("s3_seq04", 24'h020304, 2'd2, 1'b1);
    idle3(); sl3 = 1; ssel3 = 2'd3; sv3 = 8'hFF; tick();
    chk3("s3_sel3_nowrite", 24'h020304, 2'd2, 1'b1);
    ssel3 = 2'd1; sv3 = 8'hAA; tick();
    chk3("s3_sel1", 24'h02AA04, 2'd2, 1'b1);
    idle3();

    // Asynchronous reset between edges after one seq_load
    ql2 = 1; sv2 = 8'h99; tick();
    chk2("pre_areset", 16'h9900, 1'b0, 1'b0, 1'b0);
    idle2();
    #2 rst2 = 0;
    #1 chk2("areset", 16'h0000, 1'b1, 1'b0, 1'b0);
    #1 rst2 = 1;
    ql2 = 1; sv2 = 8'hAA; tick();
    chk2("post_areset", 16'hAA00, 1'b0, 1'b0, 1'b0);
    idle2();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
